mel_frame_ctrl: RTL and testbench

Frame sequencer for the mel filterbank accumulator. It accepts FFT bins from upstream over a valid/ready stream and drives the mel input as one gap-free 1024-bin burst with bin numbers. A gap in that burst makes the mel accumulators clear, so the sequencer aborts the frame instead. It then waits for the mel result, captures the NFILT accumulator values, and serializes them one per beat to the downstream log/DCT stage.

---
 rtl/mel_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mel_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_frame_ctrl.sv
// rtl/mel_frame_ctrl.sv - sequences FFT bins into the mel accumulator and serializes its NFILT results
// Optional build macro MEL_CTRL_OVERLAP_EN: drain runs from the shadow while the next frame is fed.
module mel_frame_ctrl #(
    parameter int NBINS    = 1024,
    parameter int NFILT    = 10,
    parameter int DW       = 40,
    parameter int ACC_W    = 47,
    parameter int WAIT_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_sof,
    input  logic [DW-1:0]          s_re,
    input  logic [DW-1:0]          s_im,
    output logic [DW-1:0]          mel_in_re,
    output logic [DW-1:0]          mel_in_im,
    output logic                   mel_in_valid,
    output logic [9:0]             mel_in_num,
    input  logic [NFILT*ACC_W-1:0] mel_out,
    input  logic                   mel_out_valid,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ACC_W-1:0]       m_data,
    output logic [3:0]             m_idx,
    output logic                   m_last,
    output logic [15:0]            frame_cnt,
    output logic                   err_underrun,
    output logic                   err_timeout
`ifdef MEL_CTRL_OVERLAP_EN
    ,
    output logic                   err_overrun
`endif
);

    localparam int            TW         = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [9:0]    LAST_BIN   = 10'(NBINS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(WAIT_MAX - 1);
    localparam logic [3:0]    LAST_IDX   = 4'(NFILT - 1);

    typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

    state_t            state, state_next;
    logic [9:0]        bin_cnt;
    logic [TW-1:0]     timer;
    logic [ACC_W-1:0]  shadow [NFILT];
    logic [3:0]        idx;
    logic              drain_busy;
    logic              drain_hs;
    logic              accept;
    logic              start, fwd, underrun, timeout, capture;
`ifdef MEL_CTRL_OVERLAP_EN
    logic              overrun;
`endif

    assign s_ready  = (state == IDLE) || (state == FEED);
    assign accept   = s_valid && s_ready;
    assign drain_hs = drain_busy && m_ready;
    assign m_valid  = drain_busy;
    assign m_idx    = idx;
    assign m_data   = shadow[idx];
    assign m_last   = drain_busy && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        fwd        = 1'b0;
        underrun   = 1'b0;
        timeout    = 1'b0;
        capture    = 1'b0;
`ifdef MEL_CTRL_OVERLAP_EN
        overrun    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept && s_sof) begin
                    start      = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                // Any hole in the burst would clear the mel accumulators, so abandon the frame.
                if (!s_valid) begin
                    underrun   = 1'b1;
                    state_next = IDLE;
                end else if (s_sof) begin
                    underrun   = 1'b1;
                    start      = 1'b1;
                end else begin
                    fwd = 1'b1;
                    if (bin_cnt == LAST_BIN) state_next = WAIT;
                end
            end
            WAIT: begin
                if (mel_out_valid) begin
`ifdef MEL_CTRL_OVERLAP_EN
                    state_next = IDLE;
                    if (drain_busy) overrun = 1'b1;
                    else            capture = 1'b1;
`else
                    state_next = DRAIN;
                    capture    = 1'b1;
`endif
                end else if (timer == TIMER_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (drain_hs && m_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt      <= '0;
            timer        <= '0;
            mel_in_re    <= '0;
            mel_in_im    <= '0;
            mel_in_valid <= 1'b0;
            mel_in_num   <= '0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
            idx          <= '0;
            drain_busy   <= 1'b0;
            frame_cnt    <= '0;
            for (int k = 0; k < NFILT; k++) shadow[k] <= '0;
        end else begin
            err_underrun <= underrun;
            err_timeout  <= timeout;
            mel_in_valid <= start || fwd;
            if (start) begin
                mel_in_num <= '0;
                bin_cnt    <= 10'd1;
                mel_in_re  <= s_re;
                mel_in_im  <= s_im;
            end else if (fwd) begin
                mel_in_num <= bin_cnt;
                bin_cnt    <= bin_cnt + 10'd1;
                mel_in_re  <= s_re;
                mel_in_im  <= s_im;
            end
            if (state == WAIT) timer <= timer + 1'b1;
            else               timer <= '0;
            // Shadow is only written on capture so upstream changes never reach the drain.
            if (capture) begin
                for (int k = 0; k < NFILT; k++) shadow[k] <= mel_out[k*ACC_W +: ACC_W];
                drain_busy <= 1'b1;
                idx        <= '0;
            end else if (drain_hs) begin
                if (m_last) begin
                    drain_busy <= 1'b0;
                    idx        <= '0;
                    frame_cnt  <= frame_cnt + 16'd1;
                end else begin
                    idx <= idx + 4'd1;
                end
            end
        end
    end

`ifdef MEL_CTRL_OVERLAP_EN
    always_ff @(posedge clk) begin
        if (rst)          err_overrun <= 1'b0;
        else if (overrun) err_overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mel_frame_ctrl.sv
// tb/tb_mel_frame_ctrl.sv - self-checking bench for mel_frame_ctrl (vector table, corner sequences, random frames)
module tb_mel_frame_ctrl;
    localparam int NBINS = 1024, NFILT = 10, DW = 40, ACC_W = 47, WAIT_MAX = 8;
    localparam int K_CLEAN = 0, K_GAP = 1, K_RESTART = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   s_valid, s_ready, s_sof;
    logic [DW-1:0]          s_re, s_im;
    logic [DW-1:0]          mel_in_re, mel_in_im;
    logic                   mel_in_valid;
    logic [9:0]             mel_in_num;
    logic [NFILT*ACC_W-1:0] mel_out;
    logic                   mel_out_valid;
    logic                   m_valid, m_ready, m_last;
    logic [ACC_W-1:0]       m_data;
    logic [3:0]             m_idx;
    logic [15:0]            frame_cnt;
    logic                   err_underrun, err_timeout;
`ifdef MEL_CTRL_OVERLAP_EN
    logic                   err_overrun;
`endif

    always #5 clk = ~clk;

    mel_frame_ctrl dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_re(s_re), .s_im(s_im), .mel_in_re(mel_in_re), .mel_in_im(mel_in_im),
        .mel_in_valid(mel_in_valid), .mel_in_num(mel_in_num), .mel_out(mel_out),
        .mel_out_valid(mel_out_valid), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .frame_cnt(frame_cnt),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
`ifdef MEL_CTRL_OVERLAP_EN
        , .err_overrun(err_overrun)
`endif
    );

    typedef struct { logic [9:0] num; logic [DW-1:0] re; logic [DW-1:0] im; } beat_t;
    typedef struct { logic [ACC_W-1:0] data; logic [3:0] idx; logic last; } coef_t;
    typedef struct { int kind; int pos; int lat; int base; int rdy; int dmode;
                     int exp_vals; int exp_und; int exp_to; } vec_t;

    beat_t exp_in[$];
    coef_t hs_q[$];
    int n_cmp = 0, n_fail = 0;
    int und_cnt = 0, to_cnt = 0, in_bad = 0, proto_bad = 0;
    int cyc = 0, last_bin_cyc = -1, to_cyc = -1;
    int mel_lat = 0, mel_base = 0, mel_pend = 0, data_mode = 0, exp_fc = 0;
    logic [63:0] mel_rnd;
    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mel filterbank stand-in: answers lat cycles after bin NBINS-1, garbage otherwise.
    always begin
        @(posedge clk);
        #1;
        mel_out_valid = 1'b0;
        if (mel_in_valid && mel_in_num == 10'(NBINS - 1) && mel_lat != 0) mel_pend = mel_lat;
        if (mel_pend > 0) begin
            mel_pend--;
            if (mel_pend == 0) mel_out_valid = 1'b1;
        end
        for (int k = 0; k < NFILT; k++) begin
            mel_rnd = {$urandom(), $urandom()};
            mel_out[k*ACC_W +: ACC_W] = mel_out_valid ? ACC_W'(mel_base + k) : mel_rnd[ACC_W-1:0];
        end
    end

    logic             prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_data;
    logic [3:0]       prev_idx;
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mel_in_valid) begin
                if (exp_in.size() == 0) in_bad++;
                else begin
                    e = exp_in.pop_front();
                    if (e.num !== mel_in_num || e.re !== mel_in_re || e.im !== mel_in_im) in_bad++;
                end
                if (mel_in_num == 10'(NBINS - 1)) last_bin_cyc = cyc;
            end
            if (err_underrun) und_cnt++;
            if (err_timeout) begin to_cnt++; to_cyc = cyc; end
            if (m_valid && m_ready) hs_q.push_back('{m_data, m_idx, m_last});
            if (prev_stall && !(m_valid && m_data === prev_data && m_idx === prev_idx)) proto_bad++;
`ifndef MEL_CTRL_OVERLAP_EN
            if (m_valid && s_ready) proto_bad++;
`endif
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_idx;
        end
    end

    task automatic feed_frame(input int kind, input int pos);
        int b;
        bit rs;
        logic [63:0] r;
        b  = 0;
        rs = 0;
        while (b < NBINS) begin
            if (kind == K_GAP && b == pos) begin
                s_valid = 1'b0; s_sof = 1'b0;
                tick();
                for (int j = 0; j < 5; j++) begin s_valid = 1'b1; tick(); end
                break;
            end
            if (kind == K_RESTART && b == pos && !rs) begin rs = 1; b = 0; end
            r = {$urandom(), $urandom()};
            s_valid = 1'b1;
            s_sof   = (b == 0);
            if (data_mode == 1) begin s_re = DW'(1000); s_im = '0; end
            else begin s_re = r[DW-1:0]; s_im = r[63:64-DW]; end
            exp_in.push_back('{10'(b), s_re, s_im});
            tick();
            b++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic stream_checks(input string name);
        check({name, "_mel_in"}, longint'(in_bad + exp_in.size()), 0);
        check({name, "_proto"}, longint'(proto_bad), 0);
        in_bad = 0; proto_bad = 0;
        exp_in.delete();
    endtask

    task automatic check_coefs(input string name, input int n, input int base);
        coef_t c;
        for (int k = 0; k < n && hs_q.size() > 0; k++) begin
            c = hs_q.pop_front();
            n_cmp++;
            if (c.data !== ACC_W'(base + k) || c.idx !== 4'(k) || c.last !== (k == NFILT - 1)) begin
                n_fail++;
                $display("FAIL %s_coef%0d: got data %0d idx %0d last %0b, expected data %0d idx %0d last %0b",
                         name, k, c.data, c.idx, c.last, ACC_W'(base + k), k, (k == NFILT - 1));
            end
        end
        hs_q.delete();
    endtask

    function automatic vec_t predict(input int kind, input int pos, input int lat, input int base, input int rdy);
        vec_t v;
        v.kind = kind; v.pos = pos; v.lat = lat; v.base = base; v.rdy = rdy; v.dmode = 0;
        v.exp_und  = (kind != K_CLEAN) ? 1 : 0;
        v.exp_to   = (kind != K_GAP && (lat == 0 || lat > WAIT_MAX)) ? 1 : 0;
        v.exp_vals = (kind != K_GAP && v.exp_to == 0) ? NFILT : 0;
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input string name);
        int und0, to0, waited;
        und0 = und_cnt; to0 = to_cnt;
        last_bin_cyc = -1; to_cyc = -1;
        mel_lat = v.lat; mel_base = v.base; data_mode = v.dmode;
        m_ready = 1'b1;
        feed_frame(v.kind, v.pos);
        waited = 0;
        while (waited < 200 && !(hs_q.size() >= v.exp_vals && waited >= WAIT_MAX + 4)) begin
            case (v.rdy)
                0:       m_ready = 1'b1;
                1:       m_ready = (waited % 4 == 0) || (waited % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            waited++;
        end
        m_ready = 1'b1;
        check({name, "_underrun"}, longint'(und_cnt - und0), v.exp_und);
        check({name, "_timeout"}, longint'(to_cnt - to0), v.exp_to);
        if (v.exp_to != 0) check({name, "_to_cycle"}, longint'(to_cyc - last_bin_cyc), WAIT_MAX);
        check({name, "_nvals"}, longint'(hs_q.size()), v.exp_vals);
        check_coefs(name, v.exp_vals, v.base);
        if (v.exp_vals == NFILT) exp_fc++;
        check({name, "_frame_cnt"}, longint'(frame_cnt), exp_fc & 16'hFFFF);
        check({name, "_s_ready"}, longint'(s_ready), 1);
        stream_checks(name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        tbl[0] = '{K_CLEAN,   0,   2, 100, 0, 1, 10, 0, 0};
        tbl[1] = '{K_GAP,     501, 2, 200, 0, 0, 0,  1, 0};
        tbl[2] = '{K_CLEAN,   0,   2, 150, 0, 0, 10, 0, 0};
        tbl[3] = '{K_CLEAN,   0,   3, 300, 1, 0, 10, 0, 0};
        tbl[4] = '{K_CLEAN,   0,   0, 0,   0, 0, 0,  0, 1};
        tbl[5] = '{K_RESTART, 300, 1, 400, 2, 0, 10, 1, 0};
        tbl[6] = '{K_CLEAN,   0,   8, 500, 0, 0, 10, 0, 0};
        tbl[7] = '{K_CLEAN,   0,   9, 600, 0, 0, 0,  0, 1};

        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0;
        tick(); tick();
        check("rst_s_ready", longint'(s_ready), 1);
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_mel_in_valid", longint'(mel_in_valid), 0);
        check("rst_mel_in_num", longint'(mel_in_num), 0);
        check("rst_frame_cnt", longint'(frame_cnt), 0);
        check("rst_errs", longint'({err_underrun, err_timeout}), 0);
        check("rst_m_data", longint'(m_data), 0);
        check("rst_m_last", longint'(m_last), 0);
`ifdef MEL_CTRL_OVERLAP_EN
        check("rst_err_overrun", longint'(err_overrun), 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin s_valid = 1'b1; s_sof = 1'b0; tick(); end
        s_valid = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        mel_lat = 2; mel_base = 700; data_mode = 0; m_ready = 1'b0;
        feed_frame(K_CLEAN, 0);
        w = 0;
        while (!m_valid && w < 20) begin tick(); w++; end
        check("rstdrain_m_valid", longint'(m_valid), 1);
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;
        check("rstdrain_idx", longint'(m_idx), 4);
        rst = 1'b1;
        tick();
        check("rstdrain_after_m_valid", longint'(m_valid), 0);
        check("rstdrain_after_s_ready", longint'(s_ready), 1);
        check("rstdrain_after_frame_cnt", longint'(frame_cnt), 0);
        rst = 1'b0;
        exp_fc = 0;
        check("rstdrain_nvals", longint'(hs_q.size()), 4);
        check_coefs("rstdrain", 4, 700);
        stream_checks("rstdrain");

        for (int i = 0; i < 10; i++) begin
            int r, kind;
            r    = $urandom_range(0, 9);
            kind = (r < 6) ? K_CLEAN : (r < 8) ? K_GAP : K_RESTART;
            run_frame(predict(kind, $urandom_range(1, NBINS - 1), $urandom_range(1, WAIT_MAX + 2),
                              $urandom_range(0, 1000000), $urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

`ifdef MEL_CTRL_OVERLAP_EN
        begin
            int to0;
            to0 = to_cnt;
            mel_lat = 2; mel_base = 800; m_ready = 1'b0;
            feed_frame(K_CLEAN, 0);
            w = 0;
            while (!m_valid && w < 20) begin tick(); w++; end
            check("ovl_s_ready", longint'(s_ready), 1);
            mel_base = 900;
            feed_frame(K_CLEAN, 0);
            repeat (6) tick();
            check("ovl_err_overrun", longint'(err_overrun), 1);
            check("ovl_no_timeout", longint'(to_cnt - to0), 0);
            m_ready = 1'b1;
            w = 0;
            while (hs_q.size() < NFILT && w < 40) begin tick(); w++; end
            check("ovl_nvals", longint'(hs_q.size()), NFILT);
            check_coefs("ovl", NFILT, 800);
            exp_fc++;
            check("ovl_frame_cnt", longint'(frame_cnt), exp_fc & 16'hFFFF);
            stream_checks("ovl");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
